// File: rtl/vga_pkg.sv
// Shared VGA constants, default source geometry and the line-fetch FSM state type.
package vga_pkg;

    localparam int unsigned H_ACTIVE      = 640;
    localparam int unsigned V_ACTIVE      = 480;
    localparam int unsigned SRC_W_DEFAULT = 320;
    localparam int unsigned SRC_H_DEFAULT = 240;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } fetch_state_e;

endpackage

// File: rtl/frame_line_fetch_if.sv
// Frame-memory read port: read strobe and word address out, data back one cycle later.
interface frame_line_fetch_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned WORD_W = 16
);

    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_data;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_data
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_data
    );

endinterface

// File: rtl/line_buf_2bank.sv
// Ping-pong line buffer: two banks of WPL words, one write port, one combinational read port.
module line_buf_2bank #(
    parameter int unsigned WPL    = 20,
    parameter int unsigned WORD_W = 16,
    localparam int unsigned IDX_W = (WPL > 1) ? $clog2(WPL) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_bank,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [2][WPL];

    // Contents are deliberately not reset; every line is rewritten before display.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_bank][rd_idx];

endmodule

// File: rtl/frame_line_fetch.sv
// Streams packed 1-bit source lines from frame memory into a ping-pong buffer and emits 2x pixels.
// Define FRAME_FETCH_UNDERRUN_EN to enable sticky late-fetch detection on underrun.
module frame_line_fetch
    import vga_pkg::*;
#(
    parameter int unsigned SRC_W  = SRC_W_DEFAULT,
    parameter int unsigned SRC_H  = SRC_H_DEFAULT,
    parameter int unsigned WORD_W = 16,
    parameter int unsigned ADDR_W = 13
) (
    input  logic                pixel_clk,
    input  logic                reset_n,
    input  logic                frame_start,
    input  logic                line_start,
    input  logic                active,
    frame_line_fetch_if.master  mem,
    output logic                pixel,
    output logic                underrun
);

    localparam int unsigned WPL   = SRC_W / WORD_W;
    localparam int unsigned IDX_W = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int unsigned SUB_W = $clog2(WORD_W);
    localparam int unsigned LINES = 2 * SRC_H;
    localparam int unsigned LN_W  = $clog2(LINES + 1);
    localparam int unsigned X_W   = $clog2(2 * SRC_W);

    localparam logic [LN_W-1:0]   LN_SAT     = LN_W'(LINES);
    localparam logic [LN_W-1:0]   LN_NO_NEXT = LN_W'(LINES - 2);
    localparam logic [X_W-1:0]    X_MAX      = X_W'(2 * SRC_W - 1);
    localparam logic [IDX_W-1:0]  K_LAST     = IDX_W'(WPL - 1);
    localparam logic [ADDR_W-1:0] WPL_A      = ADDR_W'(WPL);

    fetch_state_e      state_q, state_d;
    logic [IDX_W-1:0]  k_q, k_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LN_W-1:0]   line_q, line_d;
    logic              fill_q, fill_d;
    logic              disp_q, disp_d;
    logic              blank_q, blank_d;
    logic [X_W-1:0]    x_q, x_d;
    logic              rd_valid_q;
    logic [IDX_W-1:0]  rd_idx_q;
    logic              rd_bank_q;
    logic              pixel_q, pixel_d;

    logic              ls_take, swap, more, fetch_req, kill;
    logic [X_W-1:0]    col;
    logic [IDX_W-1:0]  rd_word;
    logic [SUB_W-1:0]  rd_bit;
    logic [WORD_W-1:0] rd_data;

    assign ls_take   = line_start & ~frame_start;
    assign swap      = ls_take & ~line_q[0] & (line_q < LN_SAT);
    // For an even line_idx, line_idx/2 + 1 < SRC_H reduces to line_idx < 2*SRC_H - 2.
    assign more      = line_q < LN_NO_NEXT;
    assign fetch_req = frame_start | (swap & more);
    assign kill      = frame_start | swap;

    assign mem.mem_rd   = (state_q == StIssue);
    assign mem.mem_addr = base_q + ADDR_W'(k_q);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        unique case (state_q)
            StIdle: ;
            StIssue: begin
                if (k_q == K_LAST) begin
                    state_d = StDrain;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StDrain: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (kill) begin
            state_d = fetch_req ? StIssue : StIdle;
            k_d     = '0;
        end
    end

    always_comb begin
        base_d  = base_q;
        line_d  = line_q;
        fill_d  = fill_q;
        disp_d  = disp_q;
        blank_d = blank_q;
        x_d     = x_q;
        if (active && (x_q != X_MAX)) begin
            x_d = x_q + 1'b1;
        end
        if (frame_start) begin
            line_d  = '0;
            fill_d  = 1'b0;
            base_d  = '0;
            blank_d = 1'b0;
        end else if (ls_take) begin
            x_d = '0;
            if (swap) begin
                disp_d = fill_q;
                fill_d = ~fill_q;
                if (more) begin
                    base_d = base_q + WPL_A;
                end
            end
            if (line_q == LN_SAT) begin
                blank_d = 1'b1;
            end else begin
                line_d = line_q + 1'b1;
            end
        end
    end

    assign col     = x_q >> 1;
    assign rd_word = IDX_W'(col >> SUB_W);
    assign rd_bit  = ~col[SUB_W-1:0];

    always_comb begin
        pixel_d = active & ~blank_q & rd_data[rd_bit];
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q     <= '0;
            line_q     <= '0;
            fill_q     <= 1'b0;
            disp_q     <= 1'b0;
            blank_q    <= 1'b0;
            x_q        <= '0;
            rd_valid_q <= 1'b0;
            rd_idx_q   <= '0;
            rd_bank_q  <= 1'b0;
            pixel_q    <= 1'b0;
        end else begin
            base_q     <= base_d;
            line_q     <= line_d;
            fill_q     <= fill_d;
            disp_q     <= disp_d;
            blank_q    <= blank_d;
            x_q        <= x_d;
            // A read issued in the same cycle as an abort belongs to the old line; drop it.
            rd_valid_q <= mem.mem_rd & ~kill;
            rd_idx_q   <= k_q;
            rd_bank_q  <= fill_q;
            pixel_q    <= pixel_d;
        end
    end

    line_buf_2bank #(
        .WPL    (WPL),
        .WORD_W (WORD_W)
    ) u_buf (
        .clk     (pixel_clk),
        .wr_en   (rd_valid_q),
        .wr_bank (rd_bank_q),
        .wr_idx  (rd_idx_q),
        .wr_data (mem.mem_data),
        .rd_bank (disp_q),
        .rd_idx  (rd_word),
        .rd_data (rd_data)
    );

    assign pixel = pixel_q;

`ifdef FRAME_FETCH_UNDERRUN_EN
    logic underrun_q;

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_q <= 1'b0;
        end else if (swap && (state_q != StIdle)) begin
            underrun_q <= 1'b1;
        end
    end

    assign underrun = underrun_q;
`else
    assign underrun = 1'b0;
`endif

endmodule

// File: doc/frame_line_fetch.md
# frame_line_fetch

Upstream pixel source for the VGA output stage. It streams packed 1-bit Bad Apple frames (320x240) from a synchronous frame memory into a ping-pong line buffer. It then emits one 1-bit pixel per `pixel_clk` during active video, doubled 2x horizontally and vertically to fill 640x480. The VGA stage supplies the frame/line strobes and the active flag, and drives `pixel` onto R/G/B.

## Interface
- `SRC_W`, default 320: source pixels per line.
- `SRC_H`, default 240: source lines per frame.
- `WORD_W`, default 16: memory word width; `SRC_W` must be a multiple of it.
- `ADDR_W`, default 13: memory address width; must hold `SRC_H*SRC_W/WORD_W` words.
- `pixel_clk` in 1: pixel clock, 25.175 MHz nominal.
- `reset_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: 1-cycle pulse in vertical blank, at least 30 cycles before the first `line_start` of the frame.
- `line_start` in 1: 1-cycle pulse in horizontal blank, before each line's active video.
- `active` in 1: high for exactly 640 cycles per visible line.
- `mem_rd` out 1: read strobe.
- `mem_addr` out ADDR_W: word address.
- `mem_data` in WORD_W: read data, valid exactly 1 cycle after `mem_rd`.
- `pixel` out 1: registered pixel value.
- `underrun` out 1: sticky fetch-late flag.

## Operation
Notation: WPL = `SRC_W/WORD_W` (20 by default).

**Fetch FSM**
- States are IDLE, ISSUE and DRAIN.
- IDLE→ISSUE on a fetch request.
- ISSUE asserts `mem_rd` for WPL consecutive cycles, with `mem_addr` = line_base + k for k = 0..WPL-1.
- ISSUE→DRAIN after the last issue.
- DRAIN writes the final word, then →IDLE.
- Data returned for word k is written to `fill_bank[k]`.
- `line_base` is a running sum that adds WPL per source line; no multiplier is used.

**frame_start**
- Sets `line_idx` = 0, `fill_bank` = 0 and `line_base` = 0.
- Requests a fetch of source line 0.
- Aborts any fetch in progress.

**line_start** (uses the value of `line_idx` before the increment)
- Resets the x counter to 0.
- If `line_idx` is even and < 2*`SRC_H`:
  - `disp_bank` ← `fill_bank`, and `fill_bank` is toggled.
  - If `line_idx`/2 + 1 < `SRC_H`, `line_base` advances and the next source line is fetched.
- In all cases `line_idx` increments, saturating at 2*`SRC_H`.
- Once saturated, `pixel` stays 0 until the next `frame_start`.

**Pixel path**
- While `active` is high, x increments each cycle.
- Source column = x>>1; word = x>>5; bit = 15-((x>>1)&15). Pixels are MSB-first.
- `pixel` ← `disp_bank[word][bit]`.
- While `active` is low, `pixel` ← 0.

**Boundary and priority rules**
- `frame_start` and `line_start` in the same cycle: `frame_start` wins and `line_start` is ignored.
- An even-line `line_start` while the FSM is not IDLE is an underrun:
  - the partial fetch is abandoned;
  - the banks swap anyway;
  - the new fetch starts;
  - `underrun` is set.
- x saturates at 639; extra `active` cycles repeat the last pixel.

**Reset**
- All outputs reset to 0.
- The FSM resets to IDLE, and all counters and bank selects reset to 0.
- Line-buffer contents are not reset.

## Timing
- Pixel latency: `pixel` is valid 1 cycle after the `active` cycle it corresponds to. The VGA stage delays its syncs by 1 cycle to match.
- Fetch duration: WPL + 1 cycles from request to IDLE (21 cycles by default). The request is registered 1 cycle after the strobe.
- Throughput: one fetch per two VGA lines (1600 cycles available against 22 needed).
- Memory port: `mem_rd` has no back-pressure, and the memory read latency is fixed at 1.

## Configuration
- `FRAME_FETCH_UNDERRUN_EN` defined:
  - underrun detection is active;
  - `underrun` is sticky until `reset_n`.
- Not defined:
  - `underrun` is tied to 0;
  - the detection logic is removed;
  - the abandon-and-restart behaviour on an early `line_start` is unchanged.

## Structure
- The shared package `vga_pkg` holds:
  - `H_ACTIVE` = 640 and `V_ACTIVE` = 480;
  - default `SRC_W`/`SRC_H`;
  - the FSM state typedef (IDLE/ISSUE/DRAIN).
- Sub-module `line_buf_2bank` provides two WPL x WORD_W banks, with one write port (bank, index, data) and one combinational read port (bank, index).

## Test plan
- Reset mid-ISSUE, with `reset_n` low for 3 cycles: `mem_rd`=0, `pixel`=0, `underrun`=0, and no further reads until `frame_start`.
- `frame_start`, then idle: `mem_rd` is high for exactly 20 cycles with addresses 0..19 and no other reads.
- Line 0 word0=16'h8001, rest 0; line 0 active: `pixel`=1 at x=0,1 and x=30,31, 0 elsewhere. Output appears one cycle after each `active` cycle.
- Full frame with memory word = source line index: lines 2n and 2n+1 show the pattern of source line n. Fetch addresses advance by 20 per even line, and there is no read after line 239's fetch.
- `line_start` issued 10 cycles after `frame_start`: `underrun`=1 and a fetch of line 1 starts at address 20. With the macro undefined, `underrun` stays 0.
- `frame_start` and `line_start` in the same cycle: `line_idx`=0 and a single fetch starting at address 0.
